fib_display_driver: RTL

- Downstream consumer of the Fibonacci datapath's 16-bit Output bus.
- Converts the value to decimal with a sequential shift-add-3 (double-dabble) engine.
- Drives a 4-digit, common-anode, time-multiplexed seven-segment display.
- Shows the last committed result without tearing while a new conversion is in flight.

---
 rtl/fib_display_driver_if.sv | 25 ++
 rtl/fib_display_driver.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/fib_display_driver_if.sv
// Bus between the Fibonacci datapath and its seven-segment display driver.
// The datapath (master) offers a value with a one-cycle load strobe.
interface fib_display_driver_if;
    // Handshake: load is a single-cycle strobe, accepted only while busy=0 and
    // fsm_state is IDLE; busy rises on the accepting edge and falls on the edge
    // that commits digits/overflow. A load seen while busy=1 is dropped.
    logic [15:0] value;
    logic        load;
    logic        busy;
    logic [15:0] digits;
    logic        overflow;
    logic [6:0]  segments;
    logic [3:0]  anodes;
    logic [1:0]  fsm_state;

    modport master (
        output value, load,
        input  busy, digits, overflow, segments, anodes, fsm_state
    );

    modport slave (
        input  value, load,
        output busy, digits, overflow, segments, anodes, fsm_state
    );
endinterface

// File: rtl/fib_display_driver.sv
// Binary-to-BCD (double-dabble) converter feeding a 4-digit multiplexed
// common-anode seven-segment display that shows only committed results.
module fib_display_driver #(
    parameter int REFRESH_DIV   = 50000,
    parameter bit BLANK_LEADING = 1'b1
) (
    input  logic             clock,
    input  logic             reset,
    fib_display_driver_if.slave bus
);

    localparam int CW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        COMMIT = 2'd2
    } state_t;

    state_t      state, state_next;
    logic [15:0] shreg, shreg_next;
    logic [19:0] acc, acc_next, acc_adj;
    logic [3:0]  step, step_next;
    logic        busy_q, busy_next;
    logic [15:0] digits_q, digits_next;
    logic        overflow_q, overflow_next;

    logic [CW-1:0] scan_cnt;
    logic [1:0]    digit_idx;
    logic [3:0]    cur_nibble;
    logic          cur_blank;
    logic [6:0]    seg_next;
    logic [6:0]    segments_q;
    logic [3:0]    anodes_q;

    // Add-3 correction on every BCD nibble before each shift.
    always_comb begin
        acc_adj = acc;
        for (int i = 0; i < 5; i++) begin
            if (acc[4*i +: 4] >= 4'd5) begin
                acc_adj[4*i +: 4] = acc[4*i +: 4] + 4'd3;
            end
        end
    end

    always_comb begin
        state_next    = state;
        shreg_next    = shreg;
        acc_next      = acc;
        step_next     = step;
        busy_next     = busy_q;
        digits_next   = digits_q;
        overflow_next = overflow_q;
        case (state)
            IDLE: begin
                if (bus.load) begin
                    shreg_next = bus.value;
                    acc_next   = '0;
                    step_next  = '0;
                    busy_next  = 1'b1;
                    state_next = SHIFT;
                end
            end
            SHIFT: begin
                acc_next   = {acc_adj[18:0], shreg[15]};
                shreg_next = {shreg[14:0], 1'b0};
                step_next  = step + 4'd1;
                if (step == 4'd15) begin
                    state_next = COMMIT;
                end
            end
            COMMIT: begin
                digits_next   = acc[15:0];
                overflow_next = (acc[19:16] != 4'd0);
                busy_next     = 1'b0;
                state_next    = IDLE;
            end
            default: begin
                busy_next  = 1'b0;
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= IDLE;
            shreg      <= '0;
            acc        <= '0;
            step       <= '0;
            busy_q     <= 1'b0;
            digits_q   <= '0;
            overflow_q <= 1'b0;
        end else begin
            state      <= state_next;
            shreg      <= shreg_next;
            acc        <= acc_next;
            step       <= step_next;
            busy_q     <= busy_next;
            digits_q   <= digits_next;
            overflow_q <= overflow_next;
        end
    end

    function automatic logic [6:0] seg_code(input logic [3:0] n);
        case (n)
            4'd0:    seg_code = 7'b1000000;
            4'd1:    seg_code = 7'b1111001;
            4'd2:    seg_code = 7'b0100100;
            4'd3:    seg_code = 7'b0110000;
            4'd4:    seg_code = 7'b0011001;
            4'd5:    seg_code = 7'b0010010;
            4'd6:    seg_code = 7'b0000010;
            4'd7:    seg_code = 7'b1111000;
            4'd8:    seg_code = 7'b0000000;
            4'd9:    seg_code = 7'b0010000;
            default: seg_code = 7'b1111111;
        endcase
    endfunction

    // A digit is leading when it and every digit above it are zero; the ones
    // digit never counts as leading, and an overflowed value shows all four.
    always_comb begin
        cur_nibble = digits_q[{digit_idx, 2'b00} +: 4];
        case (digit_idx)
            2'd1:    cur_blank = (digits_q[15:4] == 12'd0);
            2'd2:    cur_blank = (digits_q[15:8] == 8'd0);
            2'd3:    cur_blank = (digits_q[15:12] == 4'd0);
            default: cur_blank = 1'b0;
        endcase
        cur_blank = cur_blank && BLANK_LEADING && !overflow_q;
        seg_next  = cur_blank ? 7'b1111111 : seg_code(cur_nibble);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            scan_cnt   <= '0;
            digit_idx  <= 2'd0;
            segments_q <= 7'b1000000;
            anodes_q   <= 4'b1110;
        end else begin
            if (scan_cnt == CW'(REFRESH_DIV - 1)) begin
                scan_cnt  <= '0;
                digit_idx <= digit_idx + 2'd1;
            end else begin
                scan_cnt <= scan_cnt + 1'b1;
            end
            segments_q <= seg_next;
            anodes_q   <= ~(4'b0001 << digit_idx);
        end
    end

    assign bus.busy      = busy_q;
    assign bus.digits    = digits_q;
    assign bus.overflow  = overflow_q;
    assign bus.segments  = segments_q;
    assign bus.anodes    = anodes_q;
    assign bus.fsm_state = state;

endmodule
